fetch_ctrl: RTL and testbench

Fetch-stage controller directly upstream of the instruction ROM and control decoder in the 9-bit ACDC core. It owns the program counter, the start/run/done sequencing and the `halt` flag. It also owns two small writable target lookup tables: absolute jump targets and signed branch offsets. It feeds `PC` to InstROM and consumes the `jump_en`/`branch_en`/LUT index produced by Ctrl. It also counts retired instructions.

---
 rtl/acdc_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl_target_lut.sv | 41 ++++
 rtl/fetch_ctrl.sv | 94 +++++++++
 tb/tb_fetch_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/acdc_pkg.sv
// Shared constants and types for the ACDC fetch stage.
package acdc_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 9;
  localparam int LUT_D  = 4;
  localparam int CNT_W  = 16;
  localparam int LUT_N  = 1 << LUT_D;

  localparam logic [INST_W-1:0] HALT_OP = 9'h1FF;

  typedef enum logic [1:0] {INIT, RUN, DONE} fetch_state_t;

  typedef enum logic {JUMP_TBL = 1'b0, BRANCH_TBL = 1'b1} lut_sel_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: decoder/ROM side signals, LUT write port and status outputs.
interface fetch_ctrl_if;
  import acdc_pkg::*;

  logic [INST_W-1:0] Instruction;
  logic              jump_en;
  logic              branch_en;
  logic [LUT_D-1:0]  lut_idx;
  logic              stall;
  logic              lut_we;
  logic              lut_sel;
  logic [LUT_D-1:0]  lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   PC;
  logic              inst_valid;
  logic              halt;
  logic [CNT_W-1:0]  retired;

  modport slave (
    input  Instruction, jump_en, branch_en, lut_idx, stall,
           lut_we, lut_sel, lut_waddr, lut_wdata,
    output PC, inst_valid, halt, retired
  );

  modport master (
    output Instruction, jump_en, branch_en, lut_idx, stall,
           lut_we, lut_sel, lut_waddr, lut_wdata,
    input  PC, inst_valid, halt, retired
  );

endinterface

// File: rtl/fetch_ctrl_target_lut.sv
// Jump-target and branch-offset tables: one write port open only while start
// is high, asynchronous reads indexed by the decoder. Contents survive start.
module target_lut
  import acdc_pkg::*;
(
  input  logic             CLK,
  input  logic             start,
  input  logic             we,
  input  logic             sel,
  input  logic [LUT_D-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [LUT_D-1:0] raddr,
  output logic [PC_W-1:0]  jump_tgt,
  output logic [PC_W-1:0]  branch_off
);

  logic [PC_W-1:0] jump_tbl_q   [LUT_N];
  logic [PC_W-1:0] jump_tbl_d   [LUT_N];
  logic [PC_W-1:0] branch_tbl_q [LUT_N];
  logic [PC_W-1:0] branch_tbl_d [LUT_N];

  // Next table contents: a single entry changes on a write during start.
  always_comb begin
    jump_tbl_d   = jump_tbl_q;
    branch_tbl_d = branch_tbl_q;
    if (start && we) begin
      if (lut_sel_t'(sel) == JUMP_TBL) jump_tbl_d[waddr]   = wdata;
      else                             branch_tbl_d[waddr] = wdata;
    end
  end

  // Table storage; deliberately not reset so tables load during start.
  always_ff @(posedge CLK) begin
    jump_tbl_q   <= jump_tbl_d;
    branch_tbl_q <= branch_tbl_d;
  end

  assign jump_tgt   = jump_tbl_q[raddr];
  assign branch_off = branch_tbl_q[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC, INIT/RUN/DONE sequencing, halt flag, retired count.
// Build option: define FETCH_PC_WRAP_HALT_EN to halt on sequential PC
// overflow instead of wrapping to 0.
//
// state | meaning
// INIT  | held in start, PC=0, nothing executes
// RUN   | executing Instruction at PC unless stalled
// DONE  | halted, everything frozen until start
module fetch_ctrl
  import acdc_pkg::*;
(
  input  logic         CLK,
  input  logic         start,
  fetch_ctrl_if.slave  bus
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [PC_W-1:0]  jump_tgt;
  logic [PC_W-1:0]  branch_off;
  logic             exec;

  target_lut u_lut (
    .CLK        (CLK),
    .start      (start),
    .we         (bus.lut_we),
    .sel        (bus.lut_sel),
    .waddr      (bus.lut_waddr),
    .wdata      (bus.lut_wdata),
    .raddr      (bus.lut_idx),
    .jump_tgt   (jump_tgt),
    .branch_off (branch_off)
  );

  assign exec = (state_q == RUN) && !bus.stall;

  // Next state, next PC and counter; priority stall > halt > jump > branch > +1.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    halt_d    = halt_q;
    retired_d = retired_q;
    if (start) begin
      state_d   = INIT;
      pc_d      = '0;
      halt_d    = 1'b0;
      retired_d = '0;
    end else begin
      case (state_q)
        INIT: state_d = RUN;
        RUN: begin
          if (exec) begin
            retired_d = sat_inc(retired_q);
            if (bus.Instruction == HALT_OP) begin
              state_d = DONE;
              halt_d  = 1'b1;
            end else if (bus.jump_en) begin
              pc_d = jump_tgt;
            end else if (bus.branch_en) begin
              // PC_W-bit add is identical to sign-extended add modulo 2**PC_W.
              pc_d = pc_q + branch_off;
            end
`ifdef FETCH_PC_WRAP_HALT_EN
            else if (&pc_q) begin
              state_d = DONE;
              halt_d  = 1'b1;
            end
`endif
            else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, PC, halt and counter registers.
  always_ff @(posedge CLK) begin
    state_q   <= state_d;
    pc_q      <= pc_d;
    halt_q    <= halt_d;
    retired_q <= retired_d;
  end

  assign bus.PC         = pc_q;
  assign bus.inst_valid = exec;
  assign bus.halt       = halt_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed test-plan steps followed by random traffic, all checked against an
// instruction-level reference model of the fetch stage.
module tb_fetch_ctrl;

  logic CLK;
  logic start;
  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .CLK   (CLK),
    .start (start),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = waiting after start, 1 = running, 2 = halted.
  int m_phase = -1;
  int m_pc    = 0;
  int m_halt  = 0;
  int m_ret   = 0;
  int jtab [16];
  int btab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit st, input int ins, input bit j, input bit b,
                      input int idx, input bit stl, input bit we, input bit sel,
                      input int wa, input int wd);
    int off;
    bit iv;
    start           = st;
    bus.Instruction = 9'(ins);
    bus.jump_en     = j;
    bus.branch_en   = b;
    bus.lut_idx     = 4'(idx);
    bus.stall       = stl;
    bus.lut_we      = we;
    bus.lut_sel     = sel;
    bus.lut_waddr   = 4'(wa);
    bus.lut_wdata   = 8'(wd);
    #1;
    iv = (m_phase == 1) && !stl;
    if (m_phase >= 0) chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, iv});
    if (st) begin
      if (we) begin
        if (sel) btab[wa] = wd;
        else     jtab[wa] = wd;
      end
      m_phase = 0; m_pc = 0; m_halt = 0; m_ret = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1 && !stl) begin
      if (m_ret < 65535) m_ret = m_ret + 1;
      if (ins == 'h1FF) begin
        m_phase = 2; m_halt = 1;
      end else if (j) begin
        m_pc = jtab[idx];
      end else if (b) begin
        off  = (btab[idx] >= 128) ? btab[idx] - 256 : btab[idx];
        m_pc = (m_pc + off + 256) % 256;
      end else if (m_pc == 255) begin
`ifdef FETCH_PC_WRAP_HALT_EN
        m_phase = 2; m_halt = 1;
`else
        m_pc = 0;
`endif
      end else begin
        m_pc = m_pc + 1;
      end
    end
    @(posedge CLK);
    #1;
    chk("pc", {24'd0, bus.PC}, 32'(m_pc));
    chk("halt", {31'd0, bus.halt}, 32'(m_halt));
    chk("retired", {16'd0, bus.retired}, 32'(m_ret));
  endtask

  task automatic run_seq(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ret_snap;
    // Fill every table entry during start so nothing is read back as X.
    for (int i = 0; i < 32; i++)
      step(1, 0, 0, 0, 0, 0, 1, i / 16, i % 16, $urandom_range(0, 255));
    chk("rst_pc", {24'd0, bus.PC}, 32'h0);
    chk("rst_halt", {31'd0, bus.halt}, 32'h0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 3, 'h40);
    step(1, 0, 0, 0, 0, 0, 1, 0, 5, 'h10);
    step(1, 0, 0, 0, 0, 0, 1, 0, 6, 'h07);
    step(1, 0, 0, 0, 0, 0, 1, 0, 8, 'hFD);
    step(1, 0, 0, 0, 0, 0, 1, 1, 2, 'hFC);
    step(1, 0, 0, 0, 0, 0, 1, 0, 2, 'h20);

    // Sequential fetch after release: PC 0,1,2,3,4.
    run_seq(5);
    chk("seq_pc", {24'd0, bus.PC}, 32'h4);
    chk("seq_retired", {16'd0, bus.retired}, 32'd4);

    // Jump through table entry 3.
    run_seq(1);
    step(0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    chk("jump_pc", {24'd0, bus.PC}, 32'h40);
    // Table write in RUN must be ignored.
    step(0, 0, 0, 0, 0, 0, 1, 0, 3, 'h77);
    step(0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    chk("jump_we_ignored", {24'd0, bus.PC}, 32'h40);

    // Negative branch, then jump beats branch.
    step(0, 0, 1, 0, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    chk("branch_neg", {24'd0, bus.PC}, 32'h0C);
    step(0, 0, 1, 1, 2, 0, 0, 0, 0, 0);
    chk("jump_over_branch", {24'd0, bus.PC}, 32'h20);

    // Halt at PC 7, then frozen despite jump requests.
    step(0, 0, 1, 0, 6, 0, 0, 0, 0, 0);
    step(0, 'h1FF, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_set", {31'd0, bus.halt}, 32'h1);
    ret_snap = m_ret;
    for (int k = 0; k < 10; k++) step(0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    chk("halt_pc_hold", {24'd0, bus.PC}, 32'h7);
    chk("halt_ret_hold", {16'd0, bus.retired}, 32'(ret_snap));
    step(1, 0, 0, 0, 0, 0, 1, 0, 7, 'h09);
    chk("restart_ret", {16'd0, bus.retired}, 32'h0);

    // Stall at PC 9 with a pending jump, then the jump lands.
    run_seq(1);
    step(0, 0, 1, 0, 7, 0, 0, 0, 0, 0);
    ret_snap = m_ret;
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    chk("stall_pc", {24'd0, bus.PC}, 32'h9);
    chk("stall_ret", {16'd0, bus.retired}, 32'(ret_snap));
    step(0, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    chk("stall_release", {24'd0, bus.PC}, 32'h40);

    // Sequential run across the top of the address space.
    step(0, 0, 1, 0, 8, 0, 0, 0, 0, 0);
    run_seq(2);
    chk("pc_ff", {24'd0, bus.PC}, 32'hFF);
    ret_snap = m_ret;
    run_seq(1);
`ifdef FETCH_PC_WRAP_HALT_EN
    chk("wrap_pc", {24'd0, bus.PC}, 32'hFF);
    chk("wrap_halt", {31'd0, bus.halt}, 32'h1);
`else
    chk("wrap_pc", {24'd0, bus.PC}, 32'h0);
    chk("wrap_halt", {31'd0, bus.halt}, 32'h0);
`endif
    chk("wrap_ret", {16'd0, bus.retired}, 32'(ret_snap + 1));

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit st;
      int ins;
      st  = ($urandom_range(0, 60) == 0);
      ins = ($urandom_range(0, 30) == 0) ? 'h1FF : $urandom_range(0, 'h1FE);
      step(st, ins, 1'($urandom), 1'($urandom), $urandom_range(0, 15),
           ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom),
           $urandom_range(0, 15), $urandom_range(0, 255));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
